// File: rtl/fwd_ctrl_if.sv
// fwd_ctrl_if: ID-stage hazard inputs and forwarding/stall outputs of fwd_ctrl_unit.
// stall_count and CNT_W exist only when STALL_COUNT_EN is defined.
interface fwd_ctrl_if #(
    parameter int REG_AW = 5
`ifdef STALL_COUNT_EN
  , parameter int CNT_W = 16
`endif
);
    logic              id_valid;
    logic [REG_AW-1:0] id_rs;
    logic [REG_AW-1:0] id_rt;
    logic              id_uses_rt;
    logic [REG_AW-1:0] id_dest;
    logic              id_regwrite;
    logic              id_memread;
    logic              flush;
    logic              stall;
    logic [1:0]        fwd_a_sel;
    logic [1:0]        fwd_b_sel;
`ifdef STALL_COUNT_EN
    logic [CNT_W-1:0]  stall_count;
    modport master (
        output id_valid, id_rs, id_rt, id_uses_rt, id_dest, id_regwrite, id_memread, flush,
        input  stall, fwd_a_sel, fwd_b_sel, stall_count
    );
    modport slave (
        input  id_valid, id_rs, id_rt, id_uses_rt, id_dest, id_regwrite, id_memread, flush,
        output stall, fwd_a_sel, fwd_b_sel, stall_count
    );
`else
    modport master (
        output id_valid, id_rs, id_rt, id_uses_rt, id_dest, id_regwrite, id_memread, flush,
        input  stall, fwd_a_sel, fwd_b_sel
    );
    modport slave (
        input  id_valid, id_rs, id_rt, id_uses_rt, id_dest, id_regwrite, id_memread, flush,
        output stall, fwd_a_sel, fwd_b_sel
    );
`endif
endinterface

// File: rtl/fwd_ctrl_unit.sv
// fwd_ctrl_unit: EX operand forwarding selects and one-cycle load-use stall.
// Define STALL_COUNT_EN to add the saturating stall_count output.
module fwd_ctrl_unit #(
    parameter int REG_AW = 5
`ifdef STALL_COUNT_EN
  , parameter int CNT_W = 16
`endif
) (
    input logic       clk,
    input logic       rst,
    fwd_ctrl_if.slave bus
);
    localparam logic [1:0] SEL_RF = 2'b00, SEL_EXMEM = 2'b01, SEL_MEMWB = 2'b10;
    // A producer in MEM/WB at ID time has written back before the consumer reaches EX,
    // so only ID/EX and EX/MEM need tracking here.
    logic              idex_valid_q, idex_valid_d, idex_regwrite_q, idex_regwrite_d;
    logic              idex_memread_q, idex_memread_d;
    logic [REG_AW-1:0] idex_dest_q, idex_dest_d, exmem_dest_q, exmem_dest_d;
    logic              exmem_valid_q, exmem_valid_d, exmem_regwrite_q, exmem_regwrite_d;
    logic [1:0]        fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;
    logic              idex_live, exmem_live, hazard, squash, stall_c;

    always_comb begin
        idex_live        = idex_valid_q && idex_regwrite_q && idex_dest_q != '0;
        exmem_live       = exmem_valid_q && exmem_regwrite_q && exmem_dest_q != '0;
        hazard           = bus.id_valid && idex_valid_q && idex_memread_q && idex_dest_q != '0 &&
                           (idex_dest_q == bus.id_rs || (bus.id_uses_rt && idex_dest_q == bus.id_rt));
        stall_c          = hazard && !bus.flush && !rst;
        squash           = hazard || bus.flush;
        idex_valid_d     = bus.id_valid && !squash;
        idex_dest_d      = bus.id_dest;
        idex_regwrite_d  = bus.id_regwrite;
        idex_memread_d   = bus.id_memread;
        exmem_valid_d    = idex_valid_q;
        exmem_dest_d     = idex_dest_q;
        exmem_regwrite_d = idex_regwrite_q;
        fwd_a_d = squash                                     ? SEL_RF    :
                  (idex_live && idex_dest_q == bus.id_rs)    ? SEL_EXMEM :
                  (exmem_live && exmem_dest_q == bus.id_rs)  ? SEL_MEMWB : SEL_RF;
        fwd_b_d = (squash || !bus.id_uses_rt)                ? SEL_RF    :
                  (idex_live && idex_dest_q == bus.id_rt)    ? SEL_EXMEM :
                  (exmem_live && exmem_dest_q == bus.id_rt)  ? SEL_MEMWB : SEL_RF;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idex_valid_q     <= 1'b0;
            idex_dest_q      <= '0;
            idex_regwrite_q  <= 1'b0;
            idex_memread_q   <= 1'b0;
            exmem_valid_q    <= 1'b0;
            exmem_dest_q     <= '0;
            exmem_regwrite_q <= 1'b0;
            fwd_a_q          <= SEL_RF;
            fwd_b_q          <= SEL_RF;
        end else begin
            idex_valid_q     <= idex_valid_d;
            idex_dest_q      <= idex_dest_d;
            idex_regwrite_q  <= idex_regwrite_d;
            idex_memread_q   <= idex_memread_d;
            exmem_valid_q    <= exmem_valid_d;
            exmem_dest_q     <= exmem_dest_d;
            exmem_regwrite_q <= exmem_regwrite_d;
            fwd_a_q          <= fwd_a_d;
            fwd_b_q          <= fwd_b_d;
        end
    end

    assign bus.stall     = stall_c;
    assign bus.fwd_a_sel = fwd_a_q;
    assign bus.fwd_b_sel = fwd_b_q;

`ifdef STALL_COUNT_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    always_comb stall_cnt_d = (stall_c && stall_cnt_q != '1) ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) stall_cnt_q <= '0;
        else     stall_cnt_q <= stall_cnt_d;
    end

    assign bus.stall_count = stall_cnt_q;
`endif
endmodule
